fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that lets NUM_REQ producers share the single write port of a synchronous FIFO.
- Drives the FIFO's wr_en/wdata and observes its full flag.
- Each grant is a one-cycle pulse that consumes the requester's current word.
- Supports bounded bursts per owner and keeps saturating write and stall counters for debug.

---
 rtl/fifo_wr_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, with bounded bursts.
// Zero-latency combinational grant; fifo_full blocks all grants and freezes the burst budget.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_WIDTH = 16,
  parameter int PTR_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wdata,
  output logic [PTR_WIDTH-1:0]     owner,
  output logic                     busy,
  output logic [CNT_WIDTH-1:0]     wr_cnt,
  output logic [CNT_WIDTH-1:0]     stall_cnt
);

  localparam int BC_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state, state_nxt;
  logic [PTR_WIDTH-1:0] rr_ptr, rr_ptr_nxt, owner_nxt;
  logic [PTR_WIDTH-1:0] owner_inc, base, cand, win_idx, gnt_idx;
  logic [BC_W-1:0]      burst_cnt, burst_cnt_nxt;
  logic                 win_vld, hold_owner, gnt_vld;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // A dropped owner re-arbitrates from owner+1 in the same cycle; IDLE searches from rr_ptr.
  always_comb begin
    owner_inc = ptr_inc(owner);
    base      = (state == BURST) ? owner_inc : rr_ptr;
    win_vld   = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = PTR_WIDTH'((int'(base) + k) % NUM_REQ);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    hold_owner = (state == BURST) && req[owner];
    gnt_vld    = res && !fifo_full && (hold_owner || win_vld);
    gnt_idx    = hold_owner ? owner : win_idx;
    gnt        = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
    fifo_wr_en = gnt_vld;
    fifo_wdata = gnt_vld ? req_data[gnt_idx*WIDTH +: WIDTH] : '0;
    busy       = (state == BURST);
  end

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    owner_nxt     = owner;
    burst_cnt_nxt = burst_cnt;
    if (gnt_vld) begin
      if (hold_owner) begin
        burst_cnt_nxt = burst_cnt + 1'b1;
        if (burst_cnt_nxt == BC_W'(MAX_BURST)) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = owner_inc;
        end
      end else begin
        owner_nxt     = win_idx;
        burst_cnt_nxt = BC_W'(1);
        if (MAX_BURST == 1) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = ptr_inc(win_idx);
        end else begin
          state_nxt = BURST;
        end
      end
    end else if (!fifo_full && state == BURST) begin
      state_nxt  = IDLE;
      rr_ptr_nxt = owner_inc;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      wr_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
      if (fifo_wr_en && wr_cnt != '1)
        wr_cnt <= wr_cnt + 1'b1;
      if (fifo_full && |req && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench: two arbiter instances (default, and MAX_BURST=1/CNT_WIDTH=4) on shared stimulus vs a behavioural model.
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         res = 1'b0;
  logic [N-1:0] cur_req = '0;
  logic [N*W-1:0] cur_data = '0;
  logic         cur_full = 1'b0;

  logic [N-1:0] gnt_a, gnt_b;
  logic         wr_en_a, wr_en_b, busy_a, busy_b;
  logic [W-1:0] wdata_a, wdata_b;
  logic [1:0]   owner_a, owner_b;
  logic [15:0]  wr_cnt_a, stall_cnt_a;
  logic [3:0]   wr_cnt_b, stall_cnt_b;

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(4), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .res(res), .req(cur_req), .req_data(cur_data), .gnt(gnt_a),
    .fifo_full(cur_full), .fifo_wr_en(wr_en_a), .fifo_wdata(wdata_a), .owner(owner_a),
    .busy(busy_a), .wr_cnt(wr_cnt_a), .stall_cnt(stall_cnt_a));

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(1), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .res(res), .req(cur_req), .req_data(cur_data), .gnt(gnt_b),
    .fifo_full(cur_full), .fifo_wr_en(wr_en_b), .fifo_wdata(wdata_b), .owner(owner_b),
    .busy(busy_b), .wr_cnt(wr_cnt_b), .stall_cnt(stall_cnt_b));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hist[$];

  // Model state per instance: 0 = MAX_BURST 4 / 16-bit counters, 1 = MAX_BURST 1 / 4-bit counters.
  bit m_burst[2];
  int m_rr[2], m_own[2], m_bc[2], m_wr[2], m_st[2];
  int m_mb[2]   = '{4, 1};
  int m_cmax[2] = '{65535, 15};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] slice(input int g);
    return (g < 0) ? '0 : cur_data[g*W +: W];
  endfunction

  function automatic int pick(input int s);
    int base;
    if (!res || cur_full) return -1;
    if (m_burst[s] && cur_req[m_own[s]]) return m_own[s];
    base = m_burst[s] ? (m_own[s] + 1) % N : m_rr[s];
    for (int k = 0; k < N; k++)
      if (cur_req[(base + k) % N]) return (base + k) % N;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      m_burst[s] = 0; m_rr[s] = 0; m_own[s] = 0; m_bc[s] = 0; m_wr[s] = 0; m_st[s] = 0;
    end
  endfunction

  function automatic void model_update(input int s, input int g);
    if (g >= 0) begin
      if (m_wr[s] < m_cmax[s]) m_wr[s]++;
      if (m_burst[s] && g == m_own[s]) begin
        m_bc[s]++;
        if (m_bc[s] == m_mb[s]) begin m_burst[s] = 0; m_rr[s] = (m_own[s] + 1) % N; end
      end else begin
        m_own[s] = g; m_bc[s] = 1;
        if (m_mb[s] == 1) begin m_burst[s] = 0; m_rr[s] = (g + 1) % N; end
        else m_burst[s] = 1;
      end
    end else if (!cur_full && m_burst[s]) begin
      m_burst[s] = 0; m_rr[s] = (m_own[s] + 1) % N;
    end
    if (cur_full && |cur_req && m_st[s] < m_cmax[s]) m_st[s]++;
  endfunction

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic step();
    int ga, gb;
    #1;
    ga = pick(0);
    gb = pick(1);
    chk("gnt_a", gnt_a, oh(ga));
    chk("wr_en_a", wr_en_a, ga >= 0);
    chk("wdata_a", wdata_a, slice(ga));
    chk("owner_a", owner_a, m_own[0]);
    chk("busy_a", busy_a, m_burst[0]);
    chk("wr_cnt_a", wr_cnt_a, m_wr[0]);
    chk("stall_cnt_a", stall_cnt_a, m_st[0]);
    chk("gnt_b", gnt_b, oh(gb));
    chk("wdata_b", wdata_b, slice(gb));
    chk("owner_b", owner_b, m_own[1]);
    chk("busy_b", busy_b, m_burst[1]);
    chk("wr_cnt_b", wr_cnt_b, m_wr[1]);
    chk("stall_cnt_b", stall_cnt_b, m_st[1]);
    hist.push_back(ga);
    @(posedge clk);
    if (res) begin
      model_update(0, ga);
      model_update(1, gb);
    end
    if (ga >= 0) cur_data[ga*W +: W] = W'($urandom);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 res = 1'b0;
    #1;
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_wr_en_a", wr_en_a, 0);
    chk("rst_wdata_a", wdata_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_owner_a", owner_a, 0);
    chk("rst_wr_cnt_a", wr_cnt_a, 0);
    chk("rst_stall_a", stall_cnt_a, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_wr_cnt_b", wr_cnt_b, 0);
    model_reset();
    @(negedge clk);
    res = 1'b1;
    hist.delete();
  endtask

  int exp2[16] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};

  initial begin
    model_reset();
    cur_data = N*W'($urandom);
    for (int i = 0; i < N; i++) cur_data[i*W +: W] = W'($urandom);
    @(negedge clk);
    cur_req = 4'b1111;
    step();
    res = 1'b1;
    hist.delete();

    // 1: single requester streams without bubbles across burst boundaries
    cur_req = 4'b0001;
    repeat (10) step();
    for (int i = 0; i < 10; i++) chk("t1_gnt_idx", hist[i], 0);
    chk("t1_wr_cnt", wr_cnt_a, 10);
    chk("t1_owner", owner_a, 0);

    // 2: all requesting -> bursts of four in round-robin order
    do_reset();
    cur_req = 4'b1111;
    repeat (16) step();
    for (int i = 0; i < 16; i++) chk("t2_order", hist[i], exp2[i]);
    chk("t2_wr_cnt", wr_cnt_a, 16);

    // 3: owner drops mid-burst, next requester granted in the same cycle
    do_reset();
    cur_req = 4'b0101;
    repeat (2) step();
    cur_req = 4'b0100;
    step();
    chk("t3_third", hist[2], 2);
    chk("t3_busy", busy_a, 1);

    // 4: full stall mid-burst keeps the remaining budget
    do_reset();
    cur_req = 4'b0010;
    repeat (2) step();
    cur_full = 1'b1;
    repeat (3) step();
    chk("t4_stall", stall_cnt_a, 3);
    cur_full = 1'b0;
    cur_req = 4'b0011;
    repeat (3) step();
    for (int i = 2; i < 5; i++) chk("t4_nogrant", hist[i], -1);
    chk("t4_g1", hist[5], 1);
    chk("t4_g2", hist[6], 1);
    chk("t4_rearb", hist[7], 0);

    // 5: reset mid-burst by owner 3, then lowest requester wins
    do_reset();
    cur_req = 4'b1000;
    repeat (2) step();
    chk("t5_busy_pre", busy_a, 1);
    do_reset();
    cur_req = 4'b1010;
    step();
    chk("t5_first", hist[0], 1);

    // 6: narrow counters saturate
    do_reset();
    cur_req = 4'b0001;
    repeat (20) step();
    chk("t6_wr_sat", wr_cnt_b, 15);
    cur_full = 1'b1;
    repeat (20) step();
    chk("t6_stall_sat", stall_cnt_b, 15);
    cur_full = 1'b0;

    // Random traffic honouring the hold-until-granted handshake
    do_reset();
    for (int c = 0; c < 600; c++) begin
      int last;
      last = (hist.size() > 0) ? hist[hist.size()-1] : -1;
      for (int i = 0; i < N; i++) begin
        if (!cur_req[i] || last == i) begin
          cur_req[i] = ($urandom_range(0, 2) != 0);
          cur_data[i*W +: W] = W'($urandom);
        end
      end
      cur_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) do_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
